// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: ID-stage operand/control bundle and stall/flush/counter responses of the hazard unit.
interface hazard_scoreboard_if #(
  parameter int REG_AW = 5,
  parameter int SC_W   = 32
);
  logic              valid_ID;
  logic [REG_AW-1:0] rs1_ID;
  logic [REG_AW-1:0] rs2_ID;
  logic              use_rs1_ID;
  logic              use_rs2_ID;
  logic [REG_AW-1:0] rd_ID;
  logic              RegWrite_ID;
  logic              MemRead_ID;
  logic              IsMul_ID;
  logic              MemWrite_ID;
  logic              IsBranch_ID;
  logic              IsJALR_ID;
  logic              BranchTaken;
  logic              stall;
  logic              flush_IFID;
  logic              flush_IDEX;
  logic [SC_W-1:0]   stall_count;
  modport master (
    output valid_ID, rs1_ID, rs2_ID, use_rs1_ID, use_rs2_ID, rd_ID, RegWrite_ID,
           MemRead_ID, IsMul_ID, MemWrite_ID, IsBranch_ID, IsJALR_ID, BranchTaken,
    input  stall, flush_IFID, flush_IDEX, stall_count
  );
  modport slave (
    input  valid_ID, rs1_ID, rs2_ID, use_rs1_ID, use_rs2_ID, rd_ID, RegWrite_ID,
           MemRead_ID, IsMul_ID, MemWrite_ID, IsBranch_ID, IsJALR_ID, BranchTaken,
    output stall, flush_IFID, flush_IDEX, stall_count
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register latency scoreboard that stalls ID until each source can be forwarded,
// catches mixed-latency WAW ordering, squashes IF/ID on taken redirects and counts stall cycles.
module hazard_scoreboard #(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int MUL_LAT  = 3,
  parameter int SC_W     = 32
) (
  input logic clk,
  input logic rst,
  hazard_scoreboard_if.slave bus
);
  localparam int P_LD  = 1 + LOAD_LAT;
  localparam int P_MUL = MUL_LAT;
  localparam int P_MAX = (P_LD > P_MUL) ? P_LD : ((P_MUL > 1) ? P_MUL : 1);
  localparam int CW    = $clog2(P_MAX + 1);
  localparam int NREG  = 2 ** REG_AW;
  logic [CW-1:0]   cnt [NREG];
  logic [SC_W-1:0] sc;
  int   p, s1, s2;
  logic haz1, haz2, waw, stall, issue, load_rd;
  always_comb begin
    p     = bus.IsMul_ID ? P_MUL : (bus.MemRead_ID ? P_LD : 1);
    s1    = (bus.IsBranch_ID | bus.IsJALR_ID) ? 0 : 1;
    s2    = (bus.IsBranch_ID | bus.IsJALR_ID) ? 0 : (bus.MemWrite_ID ? 2 : 1);
    haz1  = bus.use_rs1_ID && (bus.rs1_ID != '0) && (int'(cnt[bus.rs1_ID]) > s1);
    haz2  = bus.use_rs2_ID && (bus.rs2_ID != '0) && (int'(cnt[bus.rs2_ID]) > s2);
    waw   = bus.RegWrite_ID && (bus.rd_ID != '0) && (int'(cnt[bus.rd_ID]) > p);
    stall = ~rst & bus.valid_ID & (haz1 | haz2 | waw);
    issue = bus.valid_ID & ~stall;
    load_rd = issue & bus.RegWrite_ID & (bus.rd_ID != '0);
  end
  assign bus.stall       = stall;
  assign bus.flush_IDEX  = stall;
  assign bus.flush_IFID  = ~rst & bus.BranchTaken & bus.valid_ID & ~stall;
  assign bus.stall_count = sc;
  // a fresh write to rd replaces whatever remained of the older countdown
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) cnt[i] <= '0;
      sc <= '0;
    end else begin
      for (int i = 0; i < NREG; i++)
        cnt[i] <= (load_rd && bus.rd_ID == REG_AW'(i)) ? CW'(p) :
                  (cnt[i] != '0) ? cnt[i] - CW'(1) : '0;
      sc <= (stall && ~&sc) ? sc + SC_W'(1) : sc;
    end
  end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: three parameterisations share one ID stream; a ready-time model predicts stalls.
module tb_hazard_scoreboard;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic valid, u1, u2, rw, mr, mul, mw, br, jalr, bt;
  logic [4:0] rs1, rs2, rd;
  hazard_scoreboard_if #(.REG_AW(5), .SC_W(32)) ifa();
  hazard_scoreboard_if #(.REG_AW(5), .SC_W(32)) ifb();
  hazard_scoreboard_if #(.REG_AW(5), .SC_W(4))  ifc();
  assign {ifa.valid_ID, ifb.valid_ID, ifc.valid_ID} = {3{valid}};
  assign {ifa.rs1_ID, ifb.rs1_ID, ifc.rs1_ID} = {3{rs1}};
  assign {ifa.rs2_ID, ifb.rs2_ID, ifc.rs2_ID} = {3{rs2}};
  assign {ifa.use_rs1_ID, ifb.use_rs1_ID, ifc.use_rs1_ID} = {3{u1}};
  assign {ifa.use_rs2_ID, ifb.use_rs2_ID, ifc.use_rs2_ID} = {3{u2}};
  assign {ifa.rd_ID, ifb.rd_ID, ifc.rd_ID} = {3{rd}};
  assign {ifa.RegWrite_ID, ifb.RegWrite_ID, ifc.RegWrite_ID} = {3{rw}};
  assign {ifa.MemRead_ID, ifb.MemRead_ID, ifc.MemRead_ID} = {3{mr}};
  assign {ifa.IsMul_ID, ifb.IsMul_ID, ifc.IsMul_ID} = {3{mul}};
  assign {ifa.MemWrite_ID, ifb.MemWrite_ID, ifc.MemWrite_ID} = {3{mw}};
  assign {ifa.IsBranch_ID, ifb.IsBranch_ID, ifc.IsBranch_ID} = {3{br}};
  assign {ifa.IsJALR_ID, ifb.IsJALR_ID, ifc.IsJALR_ID} = {3{jalr}};
  assign {ifa.BranchTaken, ifb.BranchTaken, ifc.BranchTaken} = {3{bt}};
  hazard_scoreboard #(.REG_AW(5), .LOAD_LAT(1), .MUL_LAT(3), .SC_W(32)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  hazard_scoreboard #(.REG_AW(5), .LOAD_LAT(2), .MUL_LAT(3), .SC_W(32)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
  hazard_scoreboard #(.REG_AW(5), .LOAD_LAT(1), .MUL_LAT(3), .SC_W(4))  dut_c (.clk(clk), .rst(rst), .bus(ifc));
  logic st [3];
  logic fi [3];
  logic fx [3];
  logic [31:0] scnt [3];
  assign st[0] = ifa.stall;
  assign st[1] = ifb.stall;
  assign st[2] = ifc.stall;
  assign fi[0] = ifa.flush_IFID;
  assign fi[1] = ifb.flush_IFID;
  assign fi[2] = ifc.flush_IFID;
  assign fx[0] = ifa.flush_IDEX;
  assign fx[1] = ifb.flush_IDEX;
  assign fx[2] = ifc.flush_IDEX;
  assign scnt[0] = ifa.stall_count;
  assign scnt[1] = ifb.stall_count;
  assign scnt[2] = {28'd0, ifc.stall_count};
  int nchk = 0;
  int nerr = 0;
  longint now = 0;
  longint ready [3][32];
  longint sc [3];
  // model: each register has an absolute cycle at which it reaches the forwarding point
  function automatic int lld(int k);
    return (k == 1) ? 2 : 1;
  endfunction
  function automatic longint smax(int k);
    return (k == 2) ? 64'd15 : 64'hFFFF_FFFF;
  endfunction
  function automatic longint left(int k, logic [4:0] r);
    return (ready[k][r] > now) ? ready[k][r] - now : 0;
  endfunction
  function automatic longint m_p(int k);
    return mul ? 3 : (mr ? 1 + lld(k) : 1);
  endfunction
  function automatic bit m_stall(int k);
    longint s1, s2;
    s1 = (br || jalr) ? 0 : 1;
    s2 = (br || jalr) ? 0 : (mw ? 2 : 1);
    return valid && ((u1 && rs1 != 0 && left(k, rs1) > s1) ||
                     (u2 && rs2 != 0 && left(k, rs2) > s2) ||
                     (rw && rd != 0 && left(k, rd) > m_p(k)));
  endfunction
  task automatic tick();
    if (!rst)
      for (int k = 0; k < 3; k++) begin
        if (m_stall(k)) sc[k] = (sc[k] < smax(k)) ? sc[k] + 1 : sc[k];
        else if (valid && rw && rd != 0) ready[k][rd] = now + 1 + m_p(k);
      end
    @(posedge clk);
    now++;
    @(negedge clk);
    #1;
  endtask
  task automatic instr(input logic v, input logic [4:0] a, input logic ua, input logic [4:0] b,
                       input logic ub, input logic [4:0] d, input logic w, input logic m,
                       input logic x, input logic s, input logic bb, input logic j, input logic t);
    valid = v; rs1 = a; u1 = ua; rs2 = b; u2 = ub; rd = d; rw = w;
    mr = m; mul = x; mw = s; br = bb; jalr = j; bt = t;
    #1;
  endtask
  task automatic i_idle();
    instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic i_load(input logic [4:0] d, input logic [4:0] a);
    instr(1, a, 1, 0, 0, d, 1, 1, 0, 0, 0, 0, 0);
  endtask
  task automatic i_alu(input logic [4:0] d, input logic [4:0] a, input logic [4:0] b);
    instr(1, a, 1, b, 1, d, 1, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic i_mul(input logic [4:0] d, input logic [4:0] a, input logic [4:0] b);
    instr(1, a, 1, b, 1, d, 1, 0, 1, 0, 0, 0, 0);
  endtask
  task automatic i_store(input logic [4:0] base, input logic [4:0] data);
    instr(1, base, 1, data, 1, 0, 0, 0, 0, 1, 0, 0, 0);
  endtask
  task automatic i_branch(input logic [4:0] a, input logic [4:0] b, input logic t);
    instr(1, a, 1, b, 1, 0, 0, 0, 0, 0, 1, 0, t);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      sc[k] = 0;
      for (int r = 0; r < 32; r++) ready[k][r] = 0;
    end
    i_idle();
    @(posedge clk);
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
  endtask
  task automatic test_reset();
    do_reset();
    rst = 1'b1;
    i_branch(5, 0, 1);
    @(posedge clk);
    @(negedge clk);
    #1;
    nchk++; if (st[0] !== 1'b0) begin nerr++; $display("FAIL reset_stall got %b want 0", st[0]); end
    nchk++; if (fi[0] !== 1'b0) begin nerr++; $display("FAIL reset_flush_ifid got %b want 0", fi[0]); end
    nchk++; if (fx[0] !== 1'b0) begin nerr++; $display("FAIL reset_flush_idex got %b want 0", fx[0]); end
    nchk++; if (scnt[0] !== 32'd0) begin nerr++; $display("FAIL reset_count got %0d want 0", scnt[0]); end
    rst = 1'b0;
    i_idle();
  endtask
  task automatic test_load_use();
    do_reset();
    i_load(5, 1);
    nchk++; if (st[0] !== 1'b0) begin nerr++; $display("FAIL lu_load_issue got %b want 0", st[0]); end
    tick();
    i_alu(6, 5, 1);
    nchk++; if (st[0] !== 1'b1 || fx[0] !== 1'b1) begin nerr++; $display("FAIL lu_stall got stall=%b idex=%b want 1/1", st[0], fx[0]); end
    tick();
    nchk++; if (st[0] !== 1'b0) begin nerr++; $display("FAIL lu_release got %b want 0", st[0]); end
    tick();
    i_idle();
    nchk++; if (scnt[0] !== 32'd1) begin nerr++; $display("FAIL lu_count got %0d want 1", scnt[0]); end
  endtask
  task automatic test_load_branch();
    do_reset();
    i_load(5, 1);
    tick();
    i_branch(5, 0, 1);
    for (int c = 0; c < 3; c++) begin
      nchk++; if (st[1] !== 1'b1 || fi[1] !== 1'b0) begin nerr++; $display("FAIL lb_stall c%0d got stall=%b ifid=%b want 1/0", c, st[1], fi[1]); end
      tick();
    end
    nchk++; if (st[1] !== 1'b0 || fi[1] !== 1'b1) begin nerr++; $display("FAIL lb_redirect got stall=%b ifid=%b want 0/1", st[1], fi[1]); end
    tick();
    i_idle();
    nchk++; if (scnt[1] !== 32'd3) begin nerr++; $display("FAIL lb_count got %0d want 3", scnt[1]); end
  endtask
  task automatic test_load_store();
    do_reset();
    i_load(5, 1);
    tick();
    i_store(2, 5);
    nchk++; if (st[0] !== 1'b0) begin nerr++; $display("FAIL ls_data got %b want 0", st[0]); end
    tick();
    i_load(2, 1);
    tick();
    i_store(2, 5);
    nchk++; if (st[0] !== 1'b1) begin nerr++; $display("FAIL ls_base got %b want 1", st[0]); end
    tick();
    nchk++; if (st[0] !== 1'b0) begin nerr++; $display("FAIL ls_base_release got %b want 0", st[0]); end
    tick();
  endtask
  task automatic test_waw();
    do_reset();
    i_mul(7, 1, 2);
    tick();
    instr(1, 0, 1, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 2; c++) begin
      nchk++; if (st[0] !== 1'b1) begin nerr++; $display("FAIL waw_stall c%0d got %b want 1", c, st[0]); end
      tick();
    end
    nchk++; if (st[0] !== 1'b0) begin nerr++; $display("FAIL waw_issue got %b want 0", st[0]); end
    tick();
    i_branch(7, 0, 0);
    nchk++; if (st[0] !== 1'b1) begin nerr++; $display("FAIL waw_reload got %b want 1", st[0]); end
    i_alu(8, 7, 7);
    nchk++; if (st[0] !== 1'b0) begin nerr++; $display("FAIL waw_consumer got %b want 0", st[0]); end
    tick();
    i_idle();
    nchk++; if (scnt[0] !== 32'd2) begin nerr++; $display("FAIL waw_count got %0d want 2", scnt[0]); end
  endtask
  task automatic test_x0_unused();
    do_reset();
    i_load(0, 1);
    tick();
    i_alu(6, 0, 0);
    nchk++; if (st[0] !== 1'b0) begin nerr++; $display("FAIL x0_alu got %b want 0", st[0]); end
    i_branch(0, 0, 1);
    nchk++; if (st[0] !== 1'b0 || fi[0] !== 1'b1) begin nerr++; $display("FAIL x0_branch got stall=%b ifid=%b want 0/1", st[0], fi[0]); end
    tick();
    i_load(5, 1);
    tick();
    instr(1, 1, 1, 5, 0, 6, 1, 0, 0, 0, 0, 0, 0);
    nchk++; if (st[0] !== 1'b0) begin nerr++; $display("FAIL unused_rs2 got %b want 0", st[0]); end
    instr(1, 0, 1, 5, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    nchk++; if (st[0] !== 1'b0 || fi[0] !== 1'b1) begin nerr++; $display("FAIL unused_branch got stall=%b ifid=%b want 0/1", st[0], fi[0]); end
    tick();
  endtask
  task automatic test_reset_mid_stall();
    do_reset();
    i_load(5, 1);
    tick();
    i_alu(6, 5, 1);
    nchk++; if (st[0] !== 1'b1) begin nerr++; $display("FAIL rms_pre got %b want 1", st[0]); end
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      sc[k] = 0;
      for (int r = 0; r < 32; r++) ready[k][r] = 0;
    end
    #1;
    nchk++; if (st[0] !== 1'b0 || fx[0] !== 1'b0) begin nerr++; $display("FAIL rms_in_reset got stall=%b idex=%b want 0/0", st[0], fx[0]); end
    rst = 1'b0;
    #1;
    nchk++; if (st[0] !== 1'b0) begin nerr++; $display("FAIL rms_cleared got %b want 0", st[0]); end
    nchk++; if (scnt[0] !== 32'd0) begin nerr++; $display("FAIL rms_count got %0d want 0", scnt[0]); end
    tick();
  endtask
  task automatic test_saturate();
    do_reset();
    for (int n = 0; n < 11; n++) begin
      i_mul(7, 1, 2);
      tick();
      i_alu(8, 7, 7);
      repeat (3) tick();
    end
    i_idle();
    nchk++; if (scnt[2] !== 32'd15) begin nerr++; $display("FAIL sat_count got %0d want 15", scnt[2]); end
    nchk++; if (scnt[0] !== 32'd22) begin nerr++; $display("FAIL wide_count got %0d want 22", scnt[0]); end
  endtask
  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      instr($urandom_range(0, 7) != 0, 5'($urandom_range(0, 7)), 1'($urandom), 5'($urandom_range(0, 7)),
            1'($urandom), 5'($urandom_range(0, 7)), 1'($urandom), 1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 4) == 0),
            1'($urandom_range(0, 7) == 0), 1'($urandom));
      for (int k = 0; k < 3; k++) begin
        nchk++;
        if (st[k] !== m_stall(k) || fx[k] !== m_stall(k) || fi[k] !== (bt && valid && !m_stall(k)) ||
            scnt[k] !== 32'(sc[k])) begin
          nerr++;
          $display("FAIL rand n=%0d dut=%0d got stall=%b idex=%b ifid=%b cnt=%0d want stall=%b ifid=%b cnt=%0d",
                   n, k, st[k], fx[k], fi[k], scnt[k], m_stall(k), bt && valid && !m_stall(k), sc[k]);
        end
      end
      tick();
    end
    i_idle();
  endtask
  initial begin
    i_idle();
    test_reset();
    test_load_use();
    test_load_branch();
    test_load_store();
    test_waw();
    test_x0_unused();
    test_reset_mid_stall();
    test_saturate();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end
endmodule
